delay_capture_fifo: RTL and testbench

//  Downstream consumer of the fixed-delay stage. Its delayed-valid output is a level: it stays high every

---
 rtl/delay_pkg.sv | 23 ++
 rtl/delay_fifo_mem.sv | 56 +++++
 rtl/delay_capture_fifo.sv | 100 ++++++++++
 tb/tb_delay_capture_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types for the delayed-valid capture FIFO.
// DELAY_CAPTURE_TIMESTAMP_EN adds a 16-bit timestamp to each entry.
package delay_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int TS_W           = 16;

`ifdef DELAY_CAPTURE_TIMESTAMP_EN
    localparam int TS_BITS = TS_W;

    typedef struct packed {
        logic [TS_W-1:0]           ts;
        logic [DATA_W_DEFAULT-1:0] data;
    } capture_entry_t;
`else
    localparam int TS_BITS = 0;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] data;
    } capture_entry_t;
`endif

endpackage

// File: rtl/delay_fifo_mem.sv
// Entry storage for the capture FIFO: wrap-around pointers,
// occupancy counter and first-word fall-through read port.
module delay_fifo_mem #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [W-1:0]     wr_entry,
    output logic [W-1:0]     rd_entry,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Contents need no reset: the head is only observed while level != 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !rd_en) begin
                level <= level + LVL_W'(1);
            end else if (rd_en && !wr_en) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/delay_capture_fifo.sv
// Captures one word per rising edge of a delayed-valid level into a FWFT FIFO.
// DELAY_CAPTURE_TIMESTAMP_EN adds a cycle-count timestamp per word (out_timestamp).
module delay_capture_fifo
    import delay_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEFAULT,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef DELAY_CAPTURE_TIMESTAMP_EN
    output logic [TS_W-1:0]   out_timestamp,
`endif
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow
);

    localparam int ENTRY_W = DATA_W + TS_BITS;

    logic               in_valid_q;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic               rd_en;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
        end
    end

    assign push = in_valid & ~in_valid_q;
    assign pop  = out_valid & out_ready;

    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign out_valid = ~empty;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop) & ~clear;
    assign rd_en = pop & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef DELAY_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // Free-running; flush leaves the time base untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign wr_entry      = {ts_cnt, in_data};
    assign out_timestamp = out_valid ? rd_entry[ENTRY_W-1 -: TS_W] : '0;
`else
    assign wr_entry = in_data;
`endif

    assign out_data = out_valid ? rd_entry[DATA_W-1:0] : '0;

    delay_fifo_mem #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .level    (level)
    );

endmodule

// File: tb/tb_delay_capture_fifo.sv
// Directed bench for delay_capture_fifo (DATA_W=32, DEPTH=4).
// Timestamp checks are compiled in with DELAY_CAPTURE_TIMESTAMP_EN.
module tb_delay_capture_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        clear;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        full;
    logic        empty;
    logic [2:0]  level;
    logic        overflow;
`ifdef DELAY_CAPTURE_TIMESTAMP_EN
    logic [15:0] out_timestamp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_capture_fifo #(
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .clear         (clear),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef DELAY_CAPTURE_TIMESTAMP_EN
        .out_timestamp (out_timestamp),
`endif
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One rising edge of in_valid, then one low cycle.
    task automatic edge_push(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 32'hA5;
        in_valid  = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", out_data, 32'd0);

        // 1: level already high at reset release, held 10 cycles
        rst_n = 1'b1;
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", out_data, 32'hA5);
        for (int i = 0; i < 9; i++) step();
        chk("t1_level_held", 32'(level), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t1_popped_empty", 32'(empty), 32'd1);
        step();

        // 2: fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) edge_push(32'(i));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_level4", 32'(level), 32'd4);
        chk("t2_no_ovf_yet", 32'(overflow), 32'd0);
        edge_push(32'd5);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_level_still4", 32'(level), 32'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_pop_order", out_data, 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("t2_drained", 32'(empty), 32'd1);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t2_clear_ovf", 32'(overflow), 32'd0);

        // 3: push and pop together while full
        for (int i = 1; i <= 4; i++) edge_push(32'(i));
        in_data   = 32'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_level4", 32'(level), 32'd4);
        chk("t3_no_ovf", 32'(overflow), 32'd0);
        chk("t3_head", out_data, 32'd2);
        step();
        out_ready = 1'b1;
        chk("t3_seq2", out_data, 32'd2);
        step();
        chk("t3_seq3", out_data, 32'd3);
        step();
        chk("t3_seq4", out_data, 32'd4);
        step();
        chk("t3_seq9", out_data, 32'd9);
        step();
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: consumer always ready, edge every 3 cycles
        for (int i = 0; i < 3; i++) begin
            in_data  = 32'h10 + 32'(i);
            in_valid = 1'b1;
            step();
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_data", out_data, 32'h10 + 32'(i));
            chk("t4_level1", 32'(level), 32'd1);
            in_valid = 1'b0;
            step();
            chk("t4_gone", 32'(out_valid), 32'd0);
            step();
        end
        out_ready = 1'b0;

        // 5: clear with level held high
        edge_push(32'h21);
        edge_push(32'h22);
        edge_push(32'h23);
        chk("t5_level3", 32'(level), 32'd3);
        in_data  = 32'h99;
        in_valid = 1'b1;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_valid0", 32'(out_valid), 32'd0);
        chk("t5_ovf0", 32'(overflow), 32'd0);
        step();
        step();
        chk("t5_no_recapture", 32'(level), 32'd0);
        in_valid = 1'b0;
        step();

        // 6: async reset mid-burst
        edge_push(32'h31);
        edge_push(32'h32);
        chk("t6_pre_level", 32'(level), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_level", 32'(level), 32'd0);
        chk("t6_async_empty", 32'(empty), 32'd1);
        chk("t6_async_data", out_data, 32'd0);
        step();
        rst_n = 1'b1;
        // edge k after release sees counter value k
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 4) begin
                in_data  = 32'h41;
                in_valid = 1'b1;
            end
            if (k == 5) in_valid = 1'b0;
            if (k == 11) begin
                in_data  = 32'h42;
                in_valid = 1'b1;
            end
            if (k == 12) in_valid = 1'b0;
        end
        chk("t6_level2", 32'(level), 32'd2);
        chk("t6_first", out_data, 32'h41);
`ifdef DELAY_CAPTURE_TIMESTAMP_EN
        chk("t6_ts5", 32'(out_timestamp), 32'd5);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_second", out_data, 32'h42);
`ifdef DELAY_CAPTURE_TIMESTAMP_EN
        chk("t6_ts12", 32'(out_timestamp), 32'd12);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
